// File: rtl/Structures.sv
// Shared stream types and scaling constants used by the receive Mixer and by up_mixer.
package Structures;

   typedef struct packed {
      logic signed [17:0] I;
      logic signed [17:0] Q;
      logic               Valid;
   } COMPLEX_STREAM;

   typedef struct packed {
      logic signed [15:0] Data;
      logic               Valid;
   } DATA_STREAM;

   localparam int SAMPLE_WIDTH  = 18;
   localparam int OUTPUT_WIDTH  = 16;
   localparam int PRODUCT_WIDTH = 36;
   localparam int SUM_WIDTH     = 37;
   localparam int TRUNC_SHIFT   = 19;

   // Clips a Q3.15 value to Q1.15; returns {clipped, data}.
   function automatic logic [OUTPUT_WIDTH:0] saturateQ315(input logic [SAMPLE_WIDTH-1:0] x);
      logic [2:0] guard;
      guard = x[SAMPLE_WIDTH-1:OUTPUT_WIDTH-1];
      if (guard == 3'b000 || guard == 3'b111) return {1'b0, x[OUTPUT_WIDTH-1:0]};
      else if (x[SAMPLE_WIDTH-1])             return {1'b1, 16'h8000};
      else                                    return {1'b1, 16'h7FFF};
   endfunction

endpackage

// File: rtl/up_mixer.sv
// Real-output quadrature upconverter: y = I*cos - Q*sin, floored and saturated to Q1.15.
module up_mixer
   import Structures::*;
(
   input  logic          ipClk,
   input  logic          ipReset,
   input  COMPLEX_STREAM ipInput,
   input  COMPLEX_STREAM ipNCO,
   output DATA_STREAM    opOutput,
   output logic          opSaturated
);

   logic signed [SAMPLE_WIDTH-1:0]  holdCos, holdSin;
   logic signed [SAMPLE_WIDTH-1:0]  selCos, selSin;
   logic signed [SAMPLE_WIDTH-1:0]  s1I, s1Q, s1Cos, s1Sin;
   logic signed [PRODUCT_WIDTH-1:0] mulI, mulQ, prodI, prodQ;
   logic signed [SUM_WIDTH-1:0]     diff;
   logic [OUTPUT_WIDTH:0]           satResult;
   logic [3:0]                      validPipe;

   // A same-cycle NCO update wins over the holding register.
   assign selCos = ipNCO.Valid ? ipNCO.I : holdCos;
   assign selSin = ipNCO.Valid ? ipNCO.Q : holdSin;

   assign satResult = saturateQ315(SAMPLE_WIDTH'(diff >>> TRUNC_SHIFT));

   // NOTE: only control state is reset; a flushed valid pipe makes stale data unobservable.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         holdCos     <= '0;
         holdSin     <= '0;
         validPipe   <= '0;
         opOutput    <= '0;
         opSaturated <= 1'b0;
      end else begin
         if (ipNCO.Valid) begin
            holdCos <= ipNCO.I;
            holdSin <= ipNCO.Q;
         end
         validPipe      <= {validPipe[2:0], ipInput.Valid};
         opOutput.Valid <= validPipe[3];
         opSaturated    <= validPipe[3] & satResult[OUTPUT_WIDTH];
         if (validPipe[3]) opOutput.Data <= satResult[OUTPUT_WIDTH-1:0];
      end
   end

   // Products take two register levels (DSP M and P), giving four edges from capture to output.
   always_ff @(posedge ipClk) begin
      if (ipInput.Valid) begin
         s1I   <= ipInput.I;
         s1Q   <= ipInput.Q;
         s1Cos <= selCos;
         s1Sin <= selSin;
      end
      if (validPipe[0]) begin
         mulI <= PRODUCT_WIDTH'(s1I) * PRODUCT_WIDTH'(s1Cos);
         mulQ <= PRODUCT_WIDTH'(s1Q) * PRODUCT_WIDTH'(s1Sin);
      end
      if (validPipe[1]) begin
         prodI <= mulI;
         prodQ <= mulQ;
      end
      if (validPipe[2]) diff <= SUM_WIDTH'(prodI) - SUM_WIDTH'(prodQ);
   end

endmodule

// File: tb/tb_up_mixer.sv
// Directed and streaming checks of up_mixer latency, scaling, saturation, NCO bypass and reset.
module tb_up_mixer;
   import Structures::*;

   logic          ipClk = 1'b0;
   logic          ipReset;
   COMPLEX_STREAM ipInput;
   COMPLEX_STREAM ipNCO;
   DATA_STREAM    opOutput;
   logic          opSaturated;

   int total = 0;
   int bad   = 0;

   up_mixer dut (
      .ipClk      (ipClk),
      .ipReset    (ipReset),
      .ipInput    (ipInput),
      .ipNCO      (ipNCO),
      .opOutput   (opOutput),
      .opSaturated(opSaturated)
   );

   always #5 ipClk = ~ipClk;

   task automatic step();
      @(posedge ipClk);
      #1;
   endtask

   function automatic logic [16:0] refModel(input logic signed [17:0] i, q, c, s);
      longint y;
      y = longint'(i) * longint'(c) - longint'(q) * longint'(s);
      y = y >>> 19;
      if (y > 32767)  return {1'b1, 16'h7FFF};
      if (y < -32768) return {1'b1, 16'h8000};
      return {1'b0, y[15:0]};
   endfunction

   task automatic test_reset();
      ipReset = 1'b1;
      ipInput = '0;
      ipNCO   = '0;
      step();
      step();
      total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", opOutput.Valid); end
      total++; if (opOutput.Data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", opOutput.Data); end
      total++; if (opSaturated !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", opSaturated); end
      ipReset = 1'b0;
   endtask

   task automatic test_before_nco();
      ipInput = '{I: 18'h10000, Q: 18'h08000, Valid: 1'b1};
      step();
      ipInput.Valid = 1'b0;
      repeat (3) step();
      step();
      total++; if (opOutput.Valid !== 1'b1) begin bad++; $display("FAIL pre_nco_valid: got %b want 1", opOutput.Valid); end
      total++; if (opOutput.Data !== 16'h0000) begin bad++; $display("FAIL pre_nco_data: got %h want 0000", opOutput.Data); end
      step();
   endtask

   task automatic test_vector(input string name, input logic [17:0] i, q, c, s,
                              input logic [15:0] expData, input logic expSat);
      ipNCO   = '{I: c, Q: s, Valid: 1'b1};
      ipInput.Valid = 1'b0;
      step();
      ipNCO.Valid = 1'b0;
      ipInput = '{I: i, Q: q, Valid: 1'b1};
      step();
      ipInput.Valid = 1'b0;
      for (int j = 1; j < 4; j++) begin
         step();
         total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid: edge+%0d got %b want 0", name, j, opOutput.Valid); end
      end
      step();
      total++; if (opOutput.Valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b want 1", name, opOutput.Valid); end
      total++; if (opOutput.Data !== expData) begin bad++; $display("FAIL %s_data: got %h want %h", name, opOutput.Data, expData); end
      total++; if (opSaturated !== expSat) begin bad++; $display("FAIL %s_sat: got %b want %b", name, opSaturated, expSat); end
      step();
      total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL %s_strobe: got %b want 0", name, opOutput.Valid); end
      total++; if (opSaturated !== 1'b0) begin bad++; $display("FAIL %s_sat_idle: got %b want 0", name, opSaturated); end
      total++; if (opOutput.Data !== expData) begin bad++; $display("FAIL %s_hold: got %h want %h", name, opOutput.Data, expData); end
   endtask

   task automatic test_bypass();
      logic [15:0] expData [4];
      logic        expValid [4];
      expData  = '{16'hC000, 16'h2000, 16'h2000, 16'h1000};
      expValid = '{1'b1, 1'b1, 1'b0, 1'b1};
      // Hold currently 0.5; same-cycle -1 must be used.
      ipNCO   = '{I: 18'h20000, Q: 18'h00000, Valid: 1'b1};
      ipInput = '{I: 18'h10000, Q: 18'h00000, Valid: 1'b1};
      step();
      ipNCO   = '{I: 18'h10000, Q: 18'h00000, Valid: 1'b1};
      step();
      ipNCO   = '{I: 18'h08000, Q: 18'h00000, Valid: 1'b1};
      ipInput.Valid = 1'b0;
      step();
      ipNCO.Valid = 1'b0;
      ipInput.Valid = 1'b1;
      step();
      ipNCO   = '{I: 18'h1FFFF, Q: 18'h1FFFF, Valid: 1'b1};
      ipInput.Valid = 1'b0;
      step();
      ipNCO.Valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         total++; if (opOutput.Valid !== expValid[j]) begin bad++; $display("FAIL bypass_valid%0d: got %b want %b", j, opOutput.Valid, expValid[j]); end
         total++; if (opOutput.Data !== expData[j]) begin bad++; $display("FAIL bypass_data%0d: got %h want %h", j, opOutput.Data, expData[j]); end
         step();
      end
   endtask

   task automatic test_valid_pattern();
      logic pattern [5];
      pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int j = 0; j < 9; j++) begin
         ipInput = '{I: 18'h04000, Q: 18'h00000, Valid: (j < 5) ? pattern[j] : 1'b0};
         step();
         total++;
         if (opOutput.Valid !== ((j >= 4) ? pattern[j-4] : 1'b0)) begin
            bad++;
            $display("FAIL pattern_valid%0d: got %b want %b", j, opOutput.Valid, (j >= 4) ? pattern[j-4] : 1'b0);
         end
      end
      ipInput.Valid = 1'b0;
   endtask

   task automatic test_stream(input string name, input int cycles, input bit randomValid);
      logic        pv [5];
      logic [15:0] pd [5];
      logic        ps [5];
      logic signed [17:0] hc, hs, uc, us, ri, rq, rc, rs;
      logic        rv, rn;
      logic [16:0] r;
      for (int j = 0; j < 5; j++) begin pv[j] = 1'b0; pd[j] = '0; ps[j] = 1'b0; end
      hc = '0; hs = '0;
      for (int n = 0; n < cycles + 5; n++) begin
         ri = 18'($urandom); rq = 18'($urandom); rc = 18'($urandom); rs = 18'($urandom);
         rv = (n < cycles) && (!randomValid || $urandom_range(0, 1) == 1);
         rn = (n == 0) || !randomValid || $urandom_range(0, 2) == 0;
         ipInput = '{I: ri, Q: rq, Valid: rv};
         ipNCO   = '{I: rc, Q: rs, Valid: rn};
         step();
         uc = rn ? rc : hc;
         us = rn ? rs : hs;
         if (rn) begin hc = rc; hs = rs; end
         r = refModel(ri, rq, uc, us);
         for (int j = 4; j > 0; j--) begin pv[j] = pv[j-1]; pd[j] = pd[j-1]; ps[j] = ps[j-1]; end
         pv[0] = rv; pd[0] = r[15:0]; ps[0] = r[16];
         total++; if (opOutput.Valid !== pv[4]) begin bad++; $display("FAIL %s_valid@%0d: got %b want %b", name, n, opOutput.Valid, pv[4]); end
         total++; if (opSaturated !== (pv[4] & ps[4])) begin bad++; $display("FAIL %s_sat@%0d: got %b want %b", name, n, opSaturated, pv[4] & ps[4]); end
         if (pv[4]) begin
            total++; if (opOutput.Data !== pd[4]) begin bad++; $display("FAIL %s_data@%0d: got %h want %h", name, n, opOutput.Data, pd[4]); end
         end
      end
      ipInput.Valid = 1'b0;
      ipNCO.Valid   = 1'b0;
   endtask

   task automatic test_reset_midflight();
      ipNCO   = '{I: 18'h1FFFF, Q: 18'h00000, Valid: 1'b1};
      ipInput = '{I: 18'h1FFFF, Q: 18'h00000, Valid: 1'b1};
      step();
      ipNCO.Valid = 1'b0;
      step();
      step();
      ipInput.Valid = 1'b0;
      ipReset = 1'b1;
      step();
      total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", opOutput.Valid); end
      total++; if (opOutput.Data !== 16'h0000) begin bad++; $display("FAIL mid_reset_data: got %h want 0000", opOutput.Data); end
      total++; if (opSaturated !== 1'b0) begin bad++; $display("FAIL mid_reset_sat: got %b want 0", opSaturated); end
      ipReset = 1'b0;
      ipNCO   = '{I: 18'h10000, Q: 18'h00000, Valid: 1'b1};
      ipInput = '{I: 18'h10000, Q: 18'h00000, Valid: 1'b1};
      step();
      ipNCO.Valid = 1'b0;
      ipInput.Valid = 1'b0;
      for (int j = 1; j < 4; j++) begin
         total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL flushed_valid%0d: got %b want 0", j, opOutput.Valid); end
         total++; if (opOutput.Data !== 16'h0000) begin bad++; $display("FAIL flushed_data%0d: got %h want 0000", j, opOutput.Data); end
         step();
      end
      total++; if (opOutput.Valid !== 1'b0) begin bad++; $display("FAIL flushed_valid4: got %b want 0", opOutput.Valid); end
      step();
      total++; if (opOutput.Valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid: got %b want 1", opOutput.Valid); end
      total++; if (opOutput.Data !== 16'h2000) begin bad++; $display("FAIL post_reset_data: got %h want 2000", opOutput.Data); end
      step();
   endtask

   initial begin
      test_reset();
      test_before_nco();
      test_vector("basic_gain", 18'h10000, 18'h00000, 18'h10000, 18'h00000, 16'h2000, 1'b0);
      test_vector("mixed",      18'h08000, 18'h04000, 18'h10000, 18'h10000, 16'h0800, 1'b0);
      test_vector("floor_neg",  18'h00001, 18'h00000, 18'h20000, 18'h00000, 16'hFFFF, 1'b0);
      test_vector("sat_pos",    18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h1FFFF, 16'h7FFF, 1'b1);
      test_vector("sat_m1m1",   18'h20000, 18'h00000, 18'h20000, 18'h00000, 16'h7FFF, 1'b1);
      test_vector("sat_neg",    18'h20000, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 16'h8000, 1'b1);
      test_vector("hold_gain",  18'h10000, 18'h00000, 18'h10000, 18'h00000, 16'h2000, 1'b0);
      test_bypass();
      test_valid_pattern();
      test_stream("stream", 1000, 1'b0);
      test_stream("gappy", 300, 1'b1);
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
